// File: rtl/pc_npc_unit_if.sv
// Control/status bundle between the pipeline and the PC/nPC unit.
// The pipeline (master) drives advance, transfer and trap controls.
// The unit (slave) returns its registered pc/npc, trap state and saved trap PCs.
interface pc_npc_unit_if #(
  parameter int WIDTH = 32
);
  // Pipeline -> unit controls
  logic             adv;
  logic             cti_taken;
  logic [WIDTH-1:0] cti_target;
  logic             annul;
  logic             trap_req;
  logic [7:0]       trap_tt;
  logic             retry;

  // Unit -> pipeline status (all registered inside the unit)
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] npc;
  logic             valid;
  logic             in_trap;
  logic [WIDTH-1:0] tpc;
  logic [WIDTH-1:0] tnpc;
  logic             error;

  modport master (
    output adv, cti_taken, cti_target, annul, trap_req, trap_tt, retry,
    input  pc, npc, valid, in_trap, tpc, tnpc, error
  );

  modport slave (
    input  adv, cti_taken, cti_target, annul, trap_req, trap_tt, retry,
    output pc, npc, valid, in_trap, tpc, tnpc, error
  );
endinterface

// File: rtl/pc_npc_unit.sv
// SPARC-style PC/nPC unit: delayed control transfer, delay-slot annul, trap entry/retry.
// Latency: all outputs registered; traps/retry visible after one adv edge, transfers after two.
// Backpressure: adv=0 stalls the unit completely; every input is ignored on non-adv edges.
module pc_npc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               STEP     = 4,
  parameter logic [WIDTH-1:0] TBR_BASE = WIDTH'(32'h0000_1000)
) (
  input  logic         clk,
  input  logic         reset_n,
  pc_npc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_TRAP  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
  localparam logic [7:0]       TT_MISALIGN = 8'h07;

  // Architectural state
  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_npc;
  logic             r_valid;
  logic [WIDTH-1:0] r_tpc;
  logic [WIDTH-1:0] r_tnpc;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_npc_nxt;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_tpc_nxt;
  logic [WIDTH-1:0] w_tnpc_nxt;

  // Qualified controls: an annulled instruction can neither transfer nor annul.
  logic             w_ct;
  logic             w_an;
  logic             w_mis;
  logic             w_take_trap;
  logic [7:0]       w_tt;
  logic [WIDTH-1:0] w_vector;
  logic [WIDTH-1:0] w_step_npc;

  assign w_ct        = bus.cti_taken & r_valid;
  assign w_an        = bus.annul & r_valid;
  assign w_mis       = w_ct & (bus.cti_target[1:0] != 2'b00);
  assign w_take_trap = bus.trap_req | w_mis;

  // An external request outranks the internal misalign trap type.
  assign w_tt        = bus.trap_req ? bus.trap_tt : TT_MISALIGN;
  assign w_vector    = TBR_BASE | WIDTH'({w_tt, 4'b0000});

  // Sequential successor of npc; the add wraps modulo 2^WIDTH by construction.
  assign w_step_npc  = w_ct ? bus.cti_target : (r_npc + STEP_W);

  // Next-state and datapath selection; everything holds unless adv is high.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_npc_nxt   = r_npc;
    w_valid_nxt = r_valid;
    w_tpc_nxt   = r_tpc;
    w_tnpc_nxt  = r_tnpc;

    if (bus.adv) begin
      unique case (r_state)
        ST_RUN: begin
          if (w_take_trap) begin
            // Trap entry: save the interrupted pair and vector into the table.
            w_tpc_nxt   = r_pc;
            w_tnpc_nxt  = r_npc;
            w_pc_nxt    = w_vector;
            w_npc_nxt   = w_vector + STEP_W;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_TRAP;
          end else begin
            // Retry outside a handler has no meaning and falls through to a step.
            w_pc_nxt    = r_npc;
            w_npc_nxt   = w_step_npc;
            w_valid_nxt = ~w_an;
          end
        end

        ST_TRAP: begin
          if (w_take_trap) begin
            // Nested trap: the saved pair would be overwritten, so freeze instead.
            w_state_nxt = ST_ERROR;
          end else if (bus.retry) begin
            w_pc_nxt    = r_tpc;
            w_npc_nxt   = r_tnpc;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_pc_nxt    = r_npc;
            w_npc_nxt   = w_step_npc;
            w_valid_nxt = ~w_an;
          end
        end

        ST_ERROR: begin
          // Frozen until reset.
        end

        default: begin
          w_state_nxt = ST_ERROR;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_npc   <= RESET_PC + STEP_W;
      r_valid <= 1'b1;
      r_tpc   <= '0;
      r_tnpc  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_npc   <= w_npc_nxt;
      r_valid <= w_valid_nxt;
      r_tpc   <= w_tpc_nxt;
      r_tnpc  <= w_tnpc_nxt;
    end
  end

  assign bus.pc      = r_pc;
  assign bus.npc     = r_npc;
  assign bus.valid   = r_valid;
  assign bus.tpc     = r_tpc;
  assign bus.tnpc    = r_tnpc;
  assign bus.in_trap = (r_state == ST_TRAP);
  assign bus.error   = (r_state == ST_ERROR);

endmodule

// File: tb/tb_pc_npc_unit.sv
// Directed bench for pc_npc_unit: a vector table for the main walk plus
// hand-written sequences for reset, nested traps, misalign, stall and wrap.
module tb_pc_npc_unit;

  logic clk;
  logic reset_n;

  pc_npc_unit_if #(.WIDTH(32)) bus ();

  pc_npc_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0),
    .STEP    (4),
    .TBR_BASE(32'h0000_1000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        adv;
    logic        ct;
    logic [31:0] tgt;
    logic        an;
    logic        trap;
    logic [7:0]  tt;
    logic        retry;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_valid;
    logic        e_in_trap;
    logic        e_err;
    logic [31:0] e_tpc;
    logic [31:0] e_tnpc;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                         input logic valid, input logic in_trap, input logic err,
                         input logic [31:0] tpc, input logic [31:0] tnpc);
    chk({tag, " pc"},      bus.pc,             pc);
    chk({tag, " npc"},     bus.npc,            npc);
    chk({tag, " valid"},   32'(bus.valid),     32'(valid));
    chk({tag, " in_trap"}, 32'(bus.in_trap),   32'(in_trap));
    chk({tag, " error"},   32'(bus.error),     32'(err));
    chk({tag, " tpc"},     bus.tpc,            tpc);
    chk({tag, " tnpc"},    bus.tnpc,           tnpc);
  endtask

  // Drive one set of inputs, take one clock edge, settle 1 time unit past it.
  task automatic cyc(input logic adv, input logic ct, input logic [31:0] tgt, input logic an,
                     input logic trap, input logic [7:0] tt, input logic retry);
    bus.adv        = adv;
    bus.cti_taken  = ct;
    bus.cti_target = tgt;
    bus.annul      = an;
    bus.trap_req   = trap;
    bus.trap_tt    = tt;
    bus.retry      = retry;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset_check(input string tag);
    reset_n = 1'b0;
    #2;
    chk_all(tag, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    // fields: adv ct tgt an trap tt retry | pc npc valid in_trap err tpc tnpc
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 32'h4,    32'h8,    1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 32'h8,    32'hC,    1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h40,  1'b0, 1'b0, 8'h00, 1'b0, 32'hC,    32'h40,   1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 32'h40,   32'h44,   1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h80,  1'b1, 1'b0, 8'h00, 1'b0, 32'h44,   32'h80,   1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'hC0,  1'b0, 1'b0, 8'h00, 1'b0, 32'h80,   32'h84,   1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 8'h05, 1'b0, 32'h80,   32'h84,   1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 8'h05, 1'b0, 32'h1050, 32'h1054, 1'b1, 1'b1, 1'b0, 32'h80, 32'h84};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 32'h1054, 32'h1058, 1'b1, 1'b1, 1'b0, 32'h80, 32'h84};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 32'h80,   32'h84,   1'b1, 1'b0, 1'b0, 32'h80, 32'h84};
    vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1, 32'h84,   32'h88,   1'b1, 1'b0, 1'b0, 32'h80, 32'h84};
    vecs[11] = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 8'h03, 1'b0, 32'h1030, 32'h1034, 1'b1, 1'b1, 1'b0, 32'h84, 32'h88};
    vecs[12] = '{1'b1, 1'b1, 32'h42,  1'b0, 1'b0, 8'h00, 1'b0, 32'h1030, 32'h1034, 1'b1, 1'b0, 1'b1, 32'h84, 32'h88};
    vecs[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b0, 32'h1030, 32'h1034, 1'b1, 1'b0, 1'b1, 32'h84, 32'h88};
    vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 8'h09, 1'b1, 32'h1030, 32'h1034, 1'b1, 1'b0, 1'b1, 32'h84, 32'h88};

    reset_n        = 1'b0;
    bus.adv        = 1'b0;
    bus.cti_taken  = 1'b0;
    bus.cti_target = '0;
    bus.annul      = 1'b0;
    bus.trap_req   = 1'b0;
    bus.trap_tt    = '0;
    bus.retry      = 1'b0;

    // Reset values while reset is held across clock edges.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;

    // Main walk: sequential, branch, annul, stall, trap, retry, nested trap.
    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].adv, vecs[i].ct, vecs[i].tgt, vecs[i].an,
          vecs[i].trap, vecs[i].tt, vecs[i].retry);
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_npc, vecs[i].e_valid,
              vecs[i].e_in_trap, vecs[i].e_err, vecs[i].e_tpc, vecs[i].e_tnpc);
    end

    // Reset out of ERROR takes effect without a clock edge.
    async_reset_check("rst_from_error");

    // Trap at pc=0x10, then trap_req together with retry in TRAP -> ERROR.
    repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("seqB pc before trap", bus.pc, 32'h10);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 8'h05, 1'b0);
    chk_all("seqB trap", 32'h1050, 32'h1054, 1'b1, 1'b1, 1'b0, 32'h10, 32'h14);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 8'h06, 1'b1);
    chk_all("seqB nested", 32'h1050, 32'h1054, 1'b1, 1'b0, 1'b1, 32'h10, 32'h14);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 8'h00, 1'b1);
      chk_all($sformatf("seqB frozen%0d", k), 32'h1050, 32'h1054, 1'b1, 1'b0, 1'b1,
              32'h10, 32'h14);
    end
    async_reset_check("rst_from_error2");

    // Misaligned target at pc=0, then stalled edges with noisy controls.
    cyc(1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("seqC misalign", 32'h1070, 32'h1074, 1'b1, 1'b1, 1'b0, 32'h0, 32'h4);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 32'h42, 1'b1, 1'b1, 8'h01, 1'b1);
      chk_all($sformatf("seqC stall%0d", k), 32'h1070, 32'h1074, 1'b1, 1'b1, 1'b0,
              32'h0, 32'h4);
    end
    // Reset mid-trap discards the saved pair.
    async_reset_check("rst_from_trap");

    // npc wraps from 0xFFFF_FFFC to 0 silently.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("seqD br", 32'h4, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("seqD wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("seqD after", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
